// File: rtl/eaglesong_bit_matrix.sv
// Constant 16x16 Eaglesong mixing-matrix ROM: one bit out per 8-bit linear index (16*row + col),
// combinational plus a registered copy. Define EAGLESONG_BIT_MATRIX_ROW_OUT_EN to also expose the full selected row.
module eaglesong_bit_matrix (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  bit_index_to_request,
  output logic        requested_bit,
  output logic        requested_bit_q
`ifdef EAGLESONG_BIT_MATRIX_ROW_OUT_EN
  ,
  output logic [15:0] requested_row
`endif
);

  // Each row constant holds column c at bit c, so row 0 reads 1111_0101_1111_0001 from col 0 upward.
  localparam logic [15:0] ROW_00 = 16'h8FAF;
  localparam logic [15:0] ROW_01 = 16'h9F5E;
  localparam logic [15:0] ROW_02 = 16'hBEBC;
  localparam logic [15:0] ROW_03 = 16'hFD78;
  localparam logic [15:0] ROW_04 = 16'h755F;
  localparam logic [15:0] ROW_05 = 16'h6511;
  localparam logic [15:0] ROW_06 = 16'hCA22;
  localparam logic [15:0] ROW_07 = 16'h9444;
  localparam logic [15:0] ROW_08 = 16'hAF67;
  localparam logic [15:0] ROW_09 = 16'hDECE;
  localparam logic [15:0] ROW_10 = 16'h7473;
  localparam logic [15:0] ROW_11 = 16'h6049;
  localparam logic [15:0] ROW_12 = 16'hC092;
  localparam logic [15:0] ROW_13 = 16'h0F8B;
  localparam logic [15:0] ROW_14 = 16'hB8F9;
  localparam logic [15:0] ROW_15 = 16'hCB5B;

  // Row 15 in the MSBs makes MATRIX[16*row + col] equal to the linear index directly.
  localparam logic [255:0] MATRIX = {ROW_15, ROW_14, ROW_13, ROW_12, ROW_11, ROW_10, ROW_09, ROW_08,
                                     ROW_07, ROW_06, ROW_05, ROW_04, ROW_03, ROW_02, ROW_01, ROW_00};

  logic w_bit;
  logic r_bit_q;

  assign w_bit           = MATRIX[bit_index_to_request];
  assign requested_bit   = w_bit;
  assign requested_bit_q = r_bit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_q <= 1'b0;
    end else begin
      r_bit_q <= w_bit;
    end
  end

`ifdef EAGLESONG_BIT_MATRIX_ROW_OUT_EN
  logic [7:0] w_row_base;

  assign w_row_base    = {bit_index_to_request[7:4], 4'b0000};
  assign requested_row = MATRIX[w_row_base +: 16];
`endif

endmodule

// File: tb/tb_eaglesong_bit_matrix.sv
// Self-checking bench for eaglesong_bit_matrix: directed checkpoints, reset behaviour and random
// indices against a row-string model of the matrix.
`timescale 1ns/1ps
module tb_eaglesong_bit_matrix;

  logic        clk;
  logic        reset_n;
  logic [7:0]  bit_index_to_request;
  logic        requested_bit;
  logic        requested_bit_q;
`ifdef EAGLESONG_BIT_MATRIX_ROW_OUT_EN
  logic [15:0] requested_row;
`endif

  int n_vec = 0;
  int n_err = 0;

  eaglesong_bit_matrix dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .bit_index_to_request (bit_index_to_request),
    .requested_bit        (requested_bit),
    .requested_bit_q      (requested_bit_q)
`ifdef EAGLESONG_BIT_MATRIX_ROW_OUT_EN
    ,
    .requested_row        (requested_row)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix rows as read left to right, column 0 first.
  string m_rows [16] = '{
    "1111010111110001", "0111101011111001", "0011110101111101", "0001111010111111",
    "1111101010101110", "1000100010100110", "0100010001010011", "0010001000101001",
    "1110011011110101", "0111001101111011", "1100111000101110", "1001001000000110",
    "0100100100000011", "1101000111110000", "1001111100011101", "1101101011010011"
  };

  function automatic logic model_bit(input int idx);
    string s;
    s = m_rows[idx / 16];
    return (s[idx % 16] == "1");
  endfunction

  function automatic logic [15:0] model_row(input int r);
    logic [15:0] v;
    v = '0;
    for (int c = 0; c < 16; c++) v[c] = model_bit(16 * r + c);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (index %0d, t=%0t)", tag, obs, exp, bit_index_to_request, $time);
    end
  endtask

  logic [7:0] idx_prev;

  initial begin
    reset_n = 1'b0;
    bit_index_to_request = 8'd0;
    #2;
    chk("rst_q_low", {15'b0, requested_bit_q}, 16'd0);
    chk("rst_bit_valid", {15'b0, requested_bit}, {15'b0, model_bit(0)});
    repeat (2) @(posedge clk);
    #1 chk("rst_q_held", {15'b0, requested_bit_q}, 16'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 chk("q_first_edge", {15'b0, requested_bit_q}, 16'd1);

    // fixed checkpoints and asymmetry between 2 and 253
    @(negedge clk) bit_index_to_request = 8'd0;
    #1 chk("idx0", {15'b0, requested_bit}, 16'd1);
    bit_index_to_request = 8'd2;
    #1 chk("idx2", {15'b0, requested_bit}, 16'd1);
    bit_index_to_request = 8'd253;
    #1 chk("idx253", {15'b0, requested_bit}, 16'd0);

    for (int i = 0; i < 16; i++) begin
      bit_index_to_request = 8'(i);
      #1 chk("row0_sweep", {15'b0, requested_bit}, {15'b0, model_bit(i)});
    end

    // asynchronous reset between edges
    @(negedge clk) bit_index_to_request = 8'd0;
    @(posedge clk);
    #1 chk("q_idx0", {15'b0, requested_bit_q}, 16'd1);
    #1 reset_n = 1'b0;
    #1 chk("async_rst_q", {15'b0, requested_bit_q}, 16'd0);
    chk("async_rst_bit", {15'b0, requested_bit}, 16'd1);
    @(negedge clk) reset_n = 1'b1;
    #1 chk("q_after_release", {15'b0, requested_bit_q}, 16'd0);
    @(posedge clk);
    #1 chk("q_reload", {15'b0, requested_bit_q}, 16'd1);

    // index change mid-cycle
    @(negedge clk) bit_index_to_request = 8'd253;
    #1 chk("mid_bit", {15'b0, requested_bit}, 16'd0);
    chk("mid_q_hold", {15'b0, requested_bit_q}, 16'd1);
    @(posedge clk);
    #1 chk("mid_q_update", {15'b0, requested_bit_q}, 16'd0);

    // random indices, occasionally changed twice within a cycle
    idx_prev = bit_index_to_request;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bit_index_to_request = 8'($urandom_range(0, 255));
      #1 chk("rnd_bit", {15'b0, requested_bit}, {15'b0, model_bit(int'(bit_index_to_request))});
      chk("rnd_q_prev", {15'b0, requested_bit_q}, {15'b0, model_bit(int'(idx_prev))});
`ifdef EAGLESONG_BIT_MATRIX_ROW_OUT_EN
      chk("rnd_row", requested_row, model_row(int'(bit_index_to_request[7:4])));
`endif
      if ($urandom_range(0, 3) == 0) begin
        #1 bit_index_to_request = 8'($urandom_range(0, 255));
        #1 chk("rnd_bit2", {15'b0, requested_bit}, {15'b0, model_bit(int'(bit_index_to_request))});
      end
      idx_prev = bit_index_to_request;
      @(posedge clk);
      #1 chk("rnd_q", {15'b0, requested_bit_q}, {15'b0, model_bit(int'(idx_prev))});
    end

`ifdef EAGLESONG_BIT_MATRIX_ROW_OUT_EN
    @(negedge clk) bit_index_to_request = 8'd5;
    #1 chk("row_idx5", requested_row, 16'h8FAF);
    for (int i = 0; i < 256; i++) begin
      bit_index_to_request = 8'(i);
      #1 chk("row_vs_bit", {15'b0, requested_row[bit_index_to_request[3:0]]}, {15'b0, requested_bit});
      chk("row_model", requested_row, model_row(i / 16));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
